// File: rtl/fixedp_div.sv
// Pipelined signed fixed-point restoring divider, q = a / b, one quotient bit per stage.
// Build option: FIXEDP_DIV_SAT_EN clamps overflowing quotients instead of wrapping them.
module fixedp_div #(
  parameter int WIDTH = 16,
  parameter int SCALE = 10,
  parameter int LAT   = WIDTH + SCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             div_zero
);

  localparam int RW = WIDTH + 1;
  // Without saturation the top SCALE quotient bits are never looked at, so those stages skip storing them.
`ifdef FIXEDP_DIV_SAT_EN
  localparam int DROP = 0;
`else
  localparam int DROP = SCALE;
`endif
  localparam int QW = LAT - DROP;
  localparam logic [WIDTH-1:0] L_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [RW-1:0]    w_abs_b;
  logic [LAT-1:0]   w_num0;

  assign w_mag_a = a[WIDTH-1] ? -a : a;
  assign w_mag_b = b[WIDTH-1] ? -b : b;
  assign w_abs_b = {1'b0, w_mag_b};
  assign w_num0  = {w_mag_a, {SCALE{1'b0}}};

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      localparam int IW = LAT - ((gi < DROP) ? gi : DROP);
      localparam int OW = (gi < DROP) ? IW - 1 : IW;

      logic          r_valid, r_sign, r_dz, r_aneg;
      logic [OW-1:0] r_nq;
      logic [IW-1:0] w_nq_in;
      logic [RW-1:0] w_rem_in, w_div_in;
      logic          w_v_in, w_sign_in, w_dz_in, w_aneg_in;
      logic [RW:0]   w_sh;
      logic          w_ge;

      if (gi == 0) begin : g_first
        assign w_nq_in   = w_num0;
        assign w_rem_in  = '0;
        assign w_div_in  = w_abs_b;
        assign w_v_in    = in_valid;
        assign w_sign_in = a[WIDTH-1] ^ b[WIDTH-1];
        assign w_dz_in   = (b == '0);
        assign w_aneg_in = a[WIDTH-1];
      end else begin : g_link
        assign w_nq_in   = g_stage[gi-1].r_nq;
        assign w_rem_in  = g_stage[gi-1].g_carry.r_rem;
        assign w_div_in  = g_stage[gi-1].g_carry.r_div;
        assign w_v_in    = g_stage[gi-1].r_valid;
        assign w_sign_in = g_stage[gi-1].r_sign;
        assign w_dz_in   = g_stage[gi-1].r_dz;
        assign w_aneg_in = g_stage[gi-1].r_aneg;
      end

      // Dividend bits leave from the top of r_nq while quotient bits enter at the bottom.
      assign w_sh = {w_rem_in, w_nq_in[IW-1]};
      assign w_ge = (w_sh >= {1'b0, w_div_in});

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_valid <= 1'b0;
        else        r_valid <= w_v_in;
      end

      always_ff @(posedge clk) begin
        r_sign <= w_sign_in;
        r_dz   <= w_dz_in;
        r_aneg <= w_aneg_in;
      end

      if (gi < DROP) begin : g_drop
        always_ff @(posedge clk) r_nq <= w_nq_in[IW-2:0];
      end else begin : g_keep
        always_ff @(posedge clk) r_nq <= {w_nq_in[IW-2:0], w_ge};
      end

      if (gi < LAT - 1) begin : g_carry
        logic [RW-1:0] r_rem, r_div;
        logic [RW-1:0] w_diff;
        assign w_diff = w_sh[RW-1:0] - w_div_in;
        always_ff @(posedge clk) begin
          r_rem <= w_ge ? w_diff : w_sh[RW-1:0];
          r_div <= w_div_in;
        end
      end
    end
  endgenerate

  logic [QW-1:0]    w_qm;
  logic [WIDTH-1:0] w_sres, w_qres;
  logic             w_v_last, w_sign_last, w_dz_last, w_aneg_last;

  assign w_qm        = g_stage[LAT-1].r_nq;
  assign w_v_last    = g_stage[LAT-1].r_valid;
  assign w_sign_last = g_stage[LAT-1].r_sign;
  assign w_dz_last   = g_stage[LAT-1].r_dz;
  assign w_aneg_last = g_stage[LAT-1].r_aneg;
  assign w_sres      = w_sign_last ? -w_qm[WIDTH-1:0] : w_qm[WIDTH-1:0];

`ifdef FIXEDP_DIV_SAT_EN
  localparam logic [QW-1:0] L_NEG_LIM = {{(QW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [QW-1:0] L_POS_LIM = L_NEG_LIM - 1'b1;
  logic w_ovf;
  assign w_ovf = w_sign_last ? (w_qm > L_NEG_LIM) : (w_qm > L_POS_LIM);
`endif

  always_comb begin
    w_qres = w_sres;
`ifdef FIXEDP_DIV_SAT_EN
    if (w_ovf) w_qres = w_sign_last ? L_MIN : L_MAX;
`endif
    if (w_dz_last) w_qres = w_aneg_last ? L_MIN : L_MAX;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      q         <= '0;
      div_zero  <= 1'b0;
    end else begin
      out_valid <= w_v_last;
      if (w_v_last) begin
        q        <= w_qres;
        div_zero <= w_dz_last;
      end
    end
  end

endmodule
